// File: rtl/present_dropper.sv
// present_dropper
// Spawns a present where a ball was popped. The present falls one step per
// frame until it reaches the floor, lingers there for a fixed number of
// frames, and is removed when it expires or the player touches it. Touching
// it starts a timed power-up effect.
//
// Ports:
//   clk, resetN      - clock; synchronous active-low reset
//   startOfFrame     - one-cycle frame tick
//   pop, popX, popY  - ball pop pulse and its coordinates
//   presentType      - generator type, valid the cycle after pop
//   playerHit        - player overlaps the present (level)
//   presentActive    - present is drawable
//   presentX/Y       - present top-left coordinate
//   presentTypeOut   - type of the current present
//   collected        - one-cycle pulse on collection
//   collectedType    - type of the last collected present
//   effectActive     - power-up effect running
//   effectType       - type of the running or last effect
module present_dropper #(
  parameter int FLOOR_Y       = 447,
  parameter int PRESENT_H     = 16,
  parameter int FALL_STEP     = 2,
  parameter int LINGER_FRAMES = 180,
  parameter int EFFECT_FRAMES = 300
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        pop,
  input  logic [10:0] popX,
  input  logic [10:0] popY,
  input  logic [1:0]  presentType,
  input  logic        playerHit,
  output logic        presentActive,
  output logic [10:0] presentX,
  output logic [10:0] presentY,
  output logic [1:0]  presentTypeOut,
  output logic        collected,
  output logic [1:0]  collectedType,
  output logic        effectActive,
  output logic [1:0]  effectType
);

  localparam logic [10:0] LAND_Y   = 11'(FLOOR_Y - PRESENT_H);
  localparam int          LINGER_W = $clog2(LINGER_FRAMES + 1);
  localparam int          EFFECT_W = $clog2(EFFECT_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ARM, FALL, LANDED} state_t;

  state_t              state, state_next;
  logic [10:0]         pop_x, pop_x_next;
  logic [10:0]         pop_y, pop_y_next;
  logic [10:0]         pos_x_next, pos_y_next;
  logic [1:0]          type_next;
  logic [LINGER_W-1:0] linger_cnt, linger_next;
  logic                collected_next;
  logic [1:0]          collected_type_next;
  logic                effect_active_next;
  logic [1:0]          effect_type_next;
  logic [EFFECT_W-1:0] effect_cnt, effect_next;
  logic [11:0]         y_sum;
  logic                hit;

  // The present is only drawable while it is falling or lying on the floor
  assign presentActive = (state == FALL) || (state == LANDED);

  // Widened by one bit so a step past the floor near the top of the range
  // cannot wrap around and look like it is still above the floor
  assign y_sum = {1'b0, presentY} + 12'(FALL_STEP);

  assign hit = playerHit && ((state == FALL) || (state == LANDED));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      pop_x          <= '0;
      pop_y          <= '0;
      presentX       <= '0;
      presentY       <= '0;
      presentTypeOut <= '0;
      linger_cnt     <= '0;
      collected      <= 1'b0;
      collectedType  <= '0;
      effectActive   <= 1'b0;
      effectType     <= '0;
      effect_cnt     <= '0;
    end else begin
      state          <= state_next;
      pop_x          <= pop_x_next;
      pop_y          <= pop_y_next;
      presentX       <= pos_x_next;
      presentY       <= pos_y_next;
      presentTypeOut <= type_next;
      linger_cnt     <= linger_next;
      collected      <= collected_next;
      collectedType  <= collected_type_next;
      effectActive   <= effect_active_next;
      effectType     <= effect_type_next;
      effect_cnt     <= effect_next;
    end
  end

  // Next-state logic. The effect tick is evaluated first so that a
  // collection in the same cycle overrides it and reloads the timer.
  // A hit suppresses any movement or linger countdown in that cycle.
  always_comb begin
    state_next          = state;
    pop_x_next          = pop_x;
    pop_y_next          = pop_y;
    pos_x_next          = presentX;
    pos_y_next          = presentY;
    type_next           = presentTypeOut;
    linger_next         = linger_cnt;
    collected_next      = 1'b0;
    collected_type_next = collectedType;
    effect_active_next  = effectActive;
    effect_type_next    = effectType;
    effect_next         = effect_cnt;

    if (startOfFrame && effectActive) begin
      if (effect_cnt == EFFECT_W'(1)) begin
        effect_active_next = 1'b0;
      end else begin
        effect_next = effect_cnt - EFFECT_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (pop) begin
          pop_x_next = popX;
          pop_y_next = popY;
          state_next = ARM;
        end
      end
      ARM: begin
        type_next  = presentType;
        pos_x_next = pop_x;
        pos_y_next = pop_y;
        state_next = FALL;
      end
      FALL: begin
        if (!hit && startOfFrame) begin
          if (y_sum >= {1'b0, LAND_Y}) begin
            pos_y_next  = LAND_Y;
            linger_next = LINGER_W'(LINGER_FRAMES);
            state_next  = LANDED;
          end else begin
            pos_y_next = y_sum[10:0];
          end
        end
      end
      LANDED: begin
        if (!hit && startOfFrame) begin
          if (linger_cnt == LINGER_W'(1)) begin
            state_next = IDLE;
          end else begin
            linger_next = linger_cnt - LINGER_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (hit) begin
      state_next          = IDLE;
      collected_next      = 1'b1;
      collected_type_next = presentTypeOut;
      effect_active_next  = 1'b1;
      effect_type_next    = presentTypeOut;
      effect_next         = EFFECT_W'(EFFECT_FRAMES);
    end
  end

endmodule

// File: tb/tb_present_dropper.sv
// tb_present_dropper
// Drives a table of per-cycle stimulus records into present_dropper
// (LINGER_FRAMES=3, EFFECT_FRAMES=4) and compares every output against the
// expected values carried in each record, followed by a fall-time and a
// linger-time sequence from a high pop point.
module tb_present_dropper;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        pop;
  logic [10:0] popX;
  logic [10:0] popY;
  logic [1:0]  presentType;
  logic        playerHit;
  logic        presentActive;
  logic [10:0] presentX;
  logic [10:0] presentY;
  logic [1:0]  presentTypeOut;
  logic        collected;
  logic [1:0]  collectedType;
  logic        effectActive;
  logic [1:0]  effectType;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int rst_n, sof, pp, px, py, pt, hit;
    int act, x, y, t, coll, ctype, eff, etype;
  } vec_t;

  vec_t vecs[32];
  vec_t sb[$];

  present_dropper #(
    .FLOOR_Y(447), .PRESENT_H(16), .FALL_STEP(2),
    .LINGER_FRAMES(3), .EFFECT_FRAMES(4)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pop(pop),
    .popX(popX), .popY(popY), .presentType(presentType), .playerHit(playerHit),
    .presentActive(presentActive), .presentX(presentX), .presentY(presentY),
    .presentTypeOut(presentTypeOut), .collected(collected),
    .collectedType(collectedType), .effectActive(effectActive),
    .effectType(effectType)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(int rst_n, int sof, int pp, int px, int py,
                              int pt, int hit, int act, int x, int y, int t,
                              int coll, int ctype, int eff, int etype);
    vec_t v;
    v.rst_n = rst_n; v.sof = sof; v.pp = pp; v.px = px; v.py = py;
    v.pt = pt; v.hit = hit; v.act = act; v.x = x; v.y = y; v.t = t;
    v.coll = coll; v.ctype = ctype; v.eff = eff; v.etype = etype;
    return v;
  endfunction

  task automatic check_field(input string name, input int step,
                             input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL step %0d %s actual=%0d required=%0d",
               step, name, act, exp);
    end
  endtask

  task automatic drive(input int rst_n, input int sof, input int pp,
                       input int px, input int py, input int pt, input int hit);
    resetN       = (rst_n != 0);
    startOfFrame = (sof != 0);
    pop          = (pp != 0);
    popX         = 11'(px);
    popY         = 11'(py);
    presentType  = 2'(pt);
    playerHit    = (hit != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input int step);
    vec_t e;
    e = sb.pop_front();
    check_field("presentActive", step, int'(presentActive), e.act);
    check_field("presentX", step, int'(presentX), e.x);
    check_field("presentY", step, int'(presentY), e.y);
    check_field("presentTypeOut", step, int'(presentTypeOut), e.t);
    check_field("collected", step, int'(collected), e.coll);
    check_field("collectedType", step, int'(collectedType), e.ctype);
    check_field("effectActive", step, int'(effectActive), e.eff);
    check_field("effectType", step, int'(effectType), e.etype);
  endtask

  task automatic apply_stimulus(input vec_t v, input int step);
    sb.push_back(v);
    drive(v.rst_n, v.sof, v.pp, v.px, v.py, v.pt, v.hit);
    check_output(step);
  endtask

  initial begin
    int ticks;

    //           rst sof pop  px   py pt hit | act  x    y  t coll ct eff et
    vecs[0]  = mk(0, 0, 0,   0,   0, 0, 0,   0,   0,   0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 100, 421, 0, 0,   0,   0,   0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0,   0,   0, 2, 0,   1, 100, 421, 2, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0,   0,   0, 0, 0,   1, 100, 423, 2, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0,   0,   0, 0, 0,   1, 100, 425, 2, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0,   0,   0, 0, 0,   1, 100, 427, 2, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0,   0,   0, 0, 0,   1, 100, 429, 2, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0,   0,   0, 0, 0,   1, 100, 431, 2, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0,   0,   0, 0, 0,   1, 100, 431, 2, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 0,   0,   0, 0, 0,   1, 100, 431, 2, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 0,   0,   0, 0, 0,   1, 100, 431, 2, 0, 0, 0, 0);
    vecs[11] = mk(1, 1, 0,   0,   0, 0, 0,   0, 100, 431, 2, 0, 0, 0, 0);
    // pop below the floor; hit and frame tick in IDLE must be ignored
    vecs[12] = mk(1, 1, 1, 200, 440, 3, 1,   0, 100, 431, 2, 0, 0, 0, 0);
    // second pop while in ARM is ignored
    vecs[13] = mk(1, 0, 1,   5,   5, 1, 0,   1, 200, 440, 1, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 0,   0,   0, 0, 0,   1, 200, 431, 1, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 0,   0,   0, 0, 1,   0, 200, 431, 1, 1, 1, 1, 1);
    vecs[16] = mk(1, 0, 1, 300, 400, 0, 0,   0, 200, 431, 1, 0, 1, 1, 1);
    vecs[17] = mk(1, 1, 0,   0,   0, 3, 0,   1, 300, 400, 3, 0, 1, 1, 1);
    vecs[18] = mk(1, 1, 0,   0,   0, 0, 0,   1, 300, 402, 3, 0, 1, 1, 1);
    // pop during FALL is ignored
    vecs[19] = mk(1, 0, 1,   7,   9, 0, 0,   1, 300, 402, 3, 0, 1, 1, 1);
    // hit with frame tick, effect at count 2: no move, timer reloaded, type 3
    vecs[20] = mk(1, 1, 0,   0,   0, 0, 1,   0, 300, 402, 3, 1, 3, 1, 3);
    vecs[21] = mk(1, 1, 0,   0,   0, 0, 0,   0, 300, 402, 3, 0, 3, 1, 3);
    vecs[22] = mk(1, 1, 0,   0,   0, 0, 0,   0, 300, 402, 3, 0, 3, 1, 3);
    vecs[23] = mk(1, 1, 0,   0,   0, 0, 0,   0, 300, 402, 3, 0, 3, 1, 3);
    vecs[24] = mk(1, 1, 0,   0,   0, 0, 0,   0, 300, 402, 3, 0, 3, 0, 3);
    vecs[25] = mk(1, 0, 1,  50, 100, 0, 0,   0, 300, 402, 3, 0, 3, 0, 3);
    vecs[26] = mk(1, 0, 0,   0,   0, 0, 0,   1,  50, 100, 0, 0, 3, 0, 3);
    vecs[27] = mk(1, 1, 0,   0,   0, 0, 0,   1,  50, 102, 0, 0, 3, 0, 3);
    // reset mid-fall clears everything
    vecs[28] = mk(0, 1, 0,   0,   0, 0, 0,   0,   0,   0, 0, 0, 0, 0, 0);
    vecs[29] = mk(1, 0, 1,  60, 425, 0, 0,   0,   0,   0, 0, 0, 0, 0, 0);
    vecs[30] = mk(1, 0, 0,   0,   0, 2, 0,   1,  60, 425, 2, 0, 0, 0, 0);
    vecs[31] = mk(1, 1, 0,   0,   0, 0, 0,   1,  60, 427, 2, 0, 0, 0, 0);

    resetN = 1'b0; startOfFrame = 1'b0; pop = 1'b0; popX = '0; popY = '0;
    presentType = '0; playerHit = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Fall time from y=200: ceil((431-200)/2) = 116 frame ticks
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 20, 200, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    ticks = 0;
    while (presentY != 11'd431 && ticks < 300) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      ticks++;
    end
    check_field("fall_ticks", 100, ticks, 116);
    check_field("landed_active", 101, int'(presentActive), 1);
    check_field("landed_x", 102, int'(presentX), 20);

    // Landed present is visible for exactly 3 further ticks
    ticks = 0;
    while (presentActive && ticks < 20) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      ticks++;
    end
    check_field("linger_ticks", 103, ticks, 3);
    check_field("linger_type_held", 104, int'(presentTypeOut), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/present_dropper.md
# present_dropper

Consumer side of the random present generator. When a ball pop is signalled, this block spawns a present at the pop location. On the cycle after the pop it captures the generator's 2-bit type, lets the present fall one step per frame until it lands on the floor, holds it there for a fixed linger time, and removes it when it expires or the player touches it. A collection starts a timed power-up effect, reported to game control as type plus active flag.

## Interface
Parameters:
- FLOOR_Y, 447, y pixel of the floor line.
- PRESENT_H, 16, present sprite height in pixels; landing Y is LAND_Y = FLOOR_Y - PRESENT_H.
- FALL_STEP, 2, pixels added to Y per frame while falling.
- LINGER_FRAMES, 180, number of frames a landed present stays before vanishing; must be ≥1.
- EFFECT_FRAMES, 300, number of frames the power-up effect lasts; must be ≥1.

Ports:
- clk in 1: system clock.
- resetN in 1: reset, synchronous and active-low.
- startOfFrame in 1: one-cycle pulse per video frame.
- pop in 1: one-cycle pulse when a ball is popped.
- popX in 11: pop x coordinate, valid together with pop.
- popY in 11: pop y coordinate, valid together with pop.
- presentType in 2: random type from the present generator; valid one cycle after pop.
- playerHit in 1: level; player sprite overlaps the present sprite.
- presentActive out 1: present is drawable.
- presentX out 11: present top-left x coordinate.
- presentY out 11: present top-left y coordinate.
- presentTypeOut out 2: type of the current present.
- collected out 1: one-cycle pulse on collection.
- collectedType out 2: type of the collected present; held until the next collection.
- effectActive out 1: power-up effect is running.
- effectType out 2: type of the running or last effect.

## Operation
- Present FSM states: IDLE, ARM, FALL, LANDED.
- All registers are updated only on posedge clk. resetN low at an edge forces, regardless of state:
  - FSM to IDLE;
  - all outputs, coordinate registers and counters to 0;
  - this includes resets in mid-fall or mid-effect.
- IDLE:
  - pop=1: latch popX and popY, go to ARM.
  - playerHit and startOfFrame are ignored.
- ARM:
  - latch presentType into the type register; load presentX/presentY from the latched pop coordinates.
  - go to FALL. This always takes exactly one cycle.
- FALL, on startOfFrame:
  - if Y + FALL_STEP ≥ LAND_Y (12-bit compare, no wrap): Y <= LAND_Y, linger counter <= LINGER_FRAMES, go to LANDED.
  - otherwise Y <= Y + FALL_STEP.
  - a popY already at or below LAND_Y snaps to LAND_Y on the first tick.
- LANDED, on startOfFrame:
  - if the linger counter == 1: go to IDLE and clear presentActive.
  - otherwise decrement the linger counter.
- Collection: playerHit=1 in FALL or LANDED at an edge causes all of the following:
  - collected pulses high for 1 cycle;
  - collectedType <= type;
  - FSM goes to IDLE and presentActive <= 0;
  - effectActive <= 1, effectType <= type, effect counter <= EFFECT_FRAMES.
- Effect timer, independent of the FSM. On startOfFrame while effectActive:
  - if the counter == 1: effectActive <= 0 (effectType is retained);
  - otherwise decrement the counter.
- Priority when events coincide:
  - playerHit beats startOfFrame: the present is collected, with no move or linger decrement that cycle.
  - a collection on the same cycle as an effect tick reloads the counter; the tick is lost.
  - a new collection while an effect is active restarts the timer with the new type.
- pop while in ARM, FALL or LANDED is ignored; only one present exists at a time.
- pop and an expiry or collection on the same cycle: the pop is ignored (the FSM was not in IDLE).

## Timing
- pop seen at edge E: state is ARM after E; presentActive=1, valid coordinates and a valid presentTypeOut after E+1.
- The first fall step happens on the first startOfFrame after E+1.
- Fall time from popY: ceil((LAND_Y − popY)/FALL_STEP) frame ticks; minimum 1.
- The landed present is visible for exactly LINGER_FRAMES frame ticks.
- Collection: registered outputs change at the edge where playerHit=1 is sampled.
- The effect lasts exactly EFFECT_FRAMES ticks after collection.
- presentX is constant from E+1 until removal; presentTypeOut holds its value until the next ARM.

## Test plan
- Reset, then pop with popX=100, popY=421, presentType=2 one cycle later -> after E+1: presentActive=1, X=100, Y=421, presentTypeOut=2. Y goes 423, 425, 427, 429, then 431 with LANDED on the 5th tick.
- Landed present, no hit, LINGER_FRAMES=3 -> presentActive drops on the 3rd tick after landing; FSM is in IDLE.
- pop at popY=440 (below LAND_Y) -> Y=431 and LANDED on the first tick.
- playerHit during FALL on the same cycle as startOfFrame, type=1 -> collected pulses for 1 cycle, collectedType=1, Y unchanged, effectActive=1. With EFFECT_FRAMES=4, effectActive clears on the 4th later tick.
- Effect type 1 active at count 2; a second present of type 3 is collected -> effectType=3, and the counter is reloaded to EFFECT_FRAMES.
- Second pop during FALL -> ignored, coordinates unchanged. resetN low during FALL -> all outputs 0 after one edge; a pop after release works normally.
